// File: rtl/bg_pixel_shifter_pkg.sv
// Shared PPU pixel/register types, background FIFO and screen constants, BGP shade lookup.
// Pure types and functions: no latency, no flow control.
package bg_pixel_shifter_pkg;

    localparam int BG_FIFO_DEPTH = 16;
    localparam int SCREEN_W      = 160;

    typedef enum logic [1:0] {
        COLOR_0 = 2'd0,
        COLOR_1 = 2'd1,
        COLOR_2 = 2'd2,
        COLOR_3 = 2'd3
    } gb_color_t;

    typedef struct packed {
        gb_color_t  color;
        logic [2:0] palette;
        logic       bg_prio;
    } ppu_pixel_t;

    typedef struct packed {
        logic [7:0] scx;
        logic [7:0] bgp;
        logic [7:0] lcdc;
    } ppu_regs_t;

    // LCDC bit 0 clear blanks the background to the color-0 shade.
    function automatic logic [1:0] bgp_shade(input logic [7:0] bgp, input gb_color_t c,
                                             input logic bg_en);
        logic [1:0] s;
        s = bgp[1:0];
        if (bg_en) begin
            case (c)
                COLOR_1: s = bgp[3:2];
                COLOR_2: s = bgp[5:4];
                COLOR_3: s = bgp[7:6];
                default: s = bgp[1:0];
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/bg_pixel_shifter_fifo.sv
// Generic synchronous FIFO, fall-through read data, flush empties it in one cycle.
// Push while full is accepted only alongside a pop; otherwise it is ignored here.
module bg_pixel_shifter_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             wr_en, rd_en;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign rd_en   = pop & ~flush & ~empty;
    assign wr_en   = push & ~flush & (~full | rd_en);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/bg_pixel_shifter.sv
// Background pixel FIFO to LCD: drops SCX fine-scroll pixels, maps colors through BGP, one cycle pop-to-pixel.
// Pops only while dot_en and a line is active; pushes arriving full with no pop are dropped and flagged.
module bg_pixel_shifter
    import bg_pixel_shifter_pkg::*;
#(
    parameter int DEPTH    = BG_FIFO_DEPTH,
    parameter int SCREEN_W = bg_pixel_shifter_pkg::SCREEN_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dot_en,
    input  ppu_regs_t  regs,
    input  logic       line_start,
    input  logic       flush,
    input  logic       bg_push_en,
    input  ppu_pixel_t bg_push_px,
    output logic       bg_fifo_full,
    output logic       bg_fifo_empty,
    output logic       lcd_px_valid,
    output logic [7:0] lcd_x,
    output logic [1:0] lcd_shade,
    output logic       line_done,
    output logic       overflow_err
);
    localparam int         CW     = $clog2(DEPTH) + 1;
    localparam logic [7:0] LAST_X = 8'(SCREEN_W - 1);

    ppu_pixel_t    pop_px;
    logic [CW-1:0] fifo_count;
    logic          fifo_clr, do_pop, do_push, push_drop;

    logic       active_q, active_d;
    logic [2:0] discard_q, discard_d;
    logic [7:0] x_cnt_q, x_cnt_d;
    logic       valid_q, valid_d;
    logic [7:0] lcd_x_q, lcd_x_d;
    logic [1:0] shade_q, shade_d;
    logic       done_q, done_d;
    logic       ovf_q, ovf_d;

    logic unused_bits;
    assign unused_bits = ^{regs.scx[7:3], regs.lcdc[7:1], pop_px.palette, pop_px.bg_prio};

    // line_start clears the FIFO as well, so it shares the flush path.
    assign fifo_clr  = line_start | flush;
    assign do_pop    = dot_en & active_q & (fifo_count != '0) & ~fifo_clr;
    assign do_push   = bg_push_en & ~fifo_clr & (~bg_fifo_full | do_pop);
    assign push_drop = bg_push_en & ~fifo_clr & bg_fifo_full & ~do_pop;

    bg_pixel_shifter_fifo #(
        .WIDTH ($bits(ppu_pixel_t)),
        .DEPTH (DEPTH)
    ) u_pixel_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (do_push),
        .push_dat (bg_push_px),
        .pop      (do_pop),
        .flush    (fifo_clr),
        .pop_dat  (pop_px),
        .full     (bg_fifo_full),
        .empty    (bg_fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        active_d  = active_q;
        discard_d = discard_q;
        x_cnt_d   = x_cnt_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        lcd_x_d   = lcd_x_q;
        shade_d   = shade_q;
        ovf_d     = ovf_q | push_drop;
        if (line_start) begin
            active_d  = 1'b1;
            discard_d = regs.scx[2:0];
            x_cnt_d   = 8'd0;
            lcd_x_d   = 8'd0;
        end else if (do_pop) begin
            if (discard_q != 3'd0) begin
                discard_d = discard_q - 3'd1;
            end else begin
                valid_d = 1'b1;
                lcd_x_d = x_cnt_q;
                shade_d = bgp_shade(regs.bgp, pop_px.color, regs.lcdc[0]);
                x_cnt_d = x_cnt_q + 8'd1;
                if (x_cnt_q == LAST_X) begin
                    active_d = 1'b0;
                    done_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q  <= 1'b0;
            discard_q <= 3'd0;
            x_cnt_q   <= 8'd0;
            valid_q   <= 1'b0;
            lcd_x_q   <= 8'd0;
            shade_q   <= 2'd0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            active_q  <= active_d;
            discard_q <= discard_d;
            x_cnt_q   <= x_cnt_d;
            valid_q   <= valid_d;
            lcd_x_q   <= lcd_x_d;
            shade_q   <= shade_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    assign lcd_px_valid = valid_q;
    assign lcd_x        = lcd_x_q;
    assign lcd_shade    = shade_q;
    assign line_done    = done_q;
    assign overflow_err = ovf_q;

endmodule
